// File: rtl/sbuf_pkg.sv
// Shared definitions for the shared-buffer ingress path.
//   DATA_WIDTH_DEF : default data word width
//   SOP_BIT/EOP_BIT: framing bit positions above the data field of a FIFO entry,
//                    entry = {sop, eop, data}
//   port_w()       : width of a port index, never below 1
package sbuf_pkg;

    localparam int DATA_WIDTH_DEF = 64;

    localparam int SOP_BIT = 1;
    localparam int EOP_BIT = 0;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_PKT,
        WR_DROP
    } wr_state_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_XFER
    } arb_state_t;

    function automatic int port_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Show-ahead synchronous FIFO for one ingress port.
//   clk, rst          : clock, async active-high reset
//   wr_en, wr_data    : push (ignored when full)
//   rd_en, rd_data    : pop (ignored when empty); rd_data shows the head entry
//   full, almost_full : registered flags for the occupancy after the current edge;
//                       almost_full means free entries < AF_THRESH
module pkt_fifo
    import sbuf_pkg::*;
#(
    parameter int WIDTH     = DATA_WIDTH_DEF + 2,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             almost_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok     = wr_en && !full;
    assign rd_ok     = rd_en && (count != '0);
    assign count_nxt = count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count       <= count_nxt;
            full        <= (int'(count_nxt) == DEPTH);
            almost_full <= ((DEPTH - int'(count_nxt)) < AF_THRESH);
        end
    end

endmodule

// File: rtl/ingress_pkt_arbiter.sv
// Ingress stage of the shared buffer: per-port store-and-forward FIFOs with
// packet admission, serialised onto one output by packet-granular round-robin.
//   clk, rst                  : clock, async active-high reset
//   i_wr_sop/eop/vld/data     : per-port framed write streams (data flattened)
//   o_almost_full, o_full     : per-port FIFO flags
//   o_drop_cnt                : per-port saturating 16-bit drop counters
//   i_ready                   : downstream accepts the current output word
//   o_sdata/sop/eop/vld/port  : serialised output stream with source port tag
//
// Write side, per port:
//   state   | meaning
//   WR_IDLE | between packets; sop opens a packet if space allows
//   WR_PKT  | admitted packet in progress, words stored
//   WR_DROP | rejected packet in progress, words discarded until eop
// Arbiter:
//   state    | meaning
//   ARB_IDLE | pick next port holding a complete packet
//   ARB_XFER | stream granted port's packet until its eop is popped
module ingress_pkt_arbiter
    import sbuf_pkg::*;
#(
    parameter int  NUM_PORTS  = 4,
    parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int  FIFO_DEPTH = 64,
    parameter int  MAX_PKT    = 32,
    localparam int PORT_W     = port_w(NUM_PORTS)
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            i_wr_sop,
    input  logic [NUM_PORTS-1:0]            i_wr_eop,
    input  logic [NUM_PORTS-1:0]            i_wr_vld,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_wr_data,
    output logic [NUM_PORTS-1:0]            o_almost_full,
    output logic [NUM_PORTS-1:0]            o_full,
    output logic [NUM_PORTS*16-1:0]         o_drop_cnt,
    input  logic                            i_ready,
    output logic [DATA_WIDTH-1:0]           o_sdata,
    output logic                            o_sop,
    output logic                            o_eop,
    output logic                            o_vld,
    output logic [PORT_W-1:0]               o_port
);

    localparam int EW = DATA_WIDTH + 2;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] fifo_rd;
    logic [EW-1:0]        fifo_rdata [NUM_PORTS];

    arb_state_t        arb_state, arb_state_nxt;
    logic [PORT_W-1:0] grant, grant_nxt;
    logic [PORT_W-1:0] last, last_nxt;
    logic              pop_en;
    logic              found;
    int                idx;
    logic [EW-1:0]     head;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        wr_state_t     wr_state, wr_state_nxt;
        logic          wr_req;
        logic          stored_sop;
        logic          drop_inc;
        logic          fifo_wr;
        logic          eop_pop;
        logic [15:0]   drop_cnt;
        logic [CW-1:0] pkt_cnt;

        always_comb begin
            wr_state_nxt = wr_state;
            wr_req       = 1'b0;
            stored_sop   = 1'b0;
            drop_inc     = 1'b0;
            if (i_wr_vld[p]) begin
                case (wr_state)
                    WR_IDLE: begin
                        if (!i_wr_sop[p]) begin
                            drop_inc = 1'b1;
                        end else if (!o_almost_full[p]) begin
                            wr_req     = 1'b1;
                            stored_sop = 1'b1;
                            if (!i_wr_eop[p]) wr_state_nxt = WR_PKT;
                        end else begin
                            drop_inc = 1'b1;
                            if (!i_wr_eop[p]) wr_state_nxt = WR_DROP;
                        end
                    end
                    // A repeated sop inside a packet is stored as a plain body word.
                    WR_PKT: begin
                        wr_req = 1'b1;
                        if (i_wr_eop[p]) wr_state_nxt = WR_IDLE;
                    end
                    WR_DROP: begin
                        if (i_wr_eop[p]) wr_state_nxt = WR_IDLE;
                    end
                    default: wr_state_nxt = WR_IDLE;
                endcase
            end
        end

        assign fifo_wr  = wr_req && !o_full[p];
        assign fifo_rd[p] = pop_en && (grant == PORT_W'(p));
        assign eop_pop  = fifo_rd[p] && fifo_rdata[p][DATA_WIDTH+EOP_BIT];
        assign req[p]   = (pkt_cnt != '0);
        assign o_drop_cnt[p*16 +: 16] = drop_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_state <= WR_IDLE;
                drop_cnt <= '0;
                pkt_cnt  <= '0;
            end else begin
                wr_state <= wr_state_nxt;
                if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                pkt_cnt <= pkt_cnt + CW'(fifo_wr && i_wr_eop[p]) - CW'(eop_pop);
            end
        end

        pkt_fifo #(
            .WIDTH     (EW),
            .DEPTH     (FIFO_DEPTH),
            .AF_THRESH (MAX_PKT)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .wr_en       (fifo_wr),
            .wr_data     ({stored_sop, i_wr_eop[p], i_wr_data[p*DATA_WIDTH +: DATA_WIDTH]}),
            .rd_en       (fifo_rd[p]),
            .rd_data     (fifo_rdata[p]),
            .full        (o_full[p]),
            .almost_full (o_almost_full[p])
        );
    end

    assign head = fifo_rdata[grant];

    always_comb begin
        arb_state_nxt = arb_state;
        grant_nxt     = grant;
        last_nxt      = last;
        pop_en        = 1'b0;
        found         = 1'b0;
        idx           = 0;
        case (arb_state)
            ARB_IDLE: begin
                for (int i = 1; i <= NUM_PORTS; i++) begin
                    idx = (int'(last) + i) % NUM_PORTS;
                    if (!found && req[idx]) begin
                        found     = 1'b1;
                        grant_nxt = PORT_W'(idx);
                    end
                end
                if (found) arb_state_nxt = ARB_XFER;
            end
            ARB_XFER: begin
                pop_en = !o_vld || i_ready;
                if (pop_en && head[DATA_WIDTH+EOP_BIT]) begin
                    last_nxt      = grant;
                    arb_state_nxt = ARB_IDLE;
                end
            end
            default: arb_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_state <= ARB_IDLE;
            grant     <= '0;
            last      <= PORT_W'(NUM_PORTS - 1);
        end else begin
            arb_state <= arb_state_nxt;
            grant     <= grant_nxt;
            last      <= last_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sdata <= '0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
            o_vld   <= 1'b0;
            o_port  <= '0;
        end else if (pop_en) begin
            o_sdata <= head[DATA_WIDTH-1:0];
            o_sop   <= head[DATA_WIDTH+SOP_BIT];
            o_eop   <= head[DATA_WIDTH+EOP_BIT];
            o_vld   <= 1'b1;
            o_port  <= grant;
        end else if (i_ready) begin
            o_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ingress_pkt_arbiter.sv
module tb_ingress_pkt_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NP-1:0]  i_wr_sop, i_wr_eop, i_wr_vld;
    logic [NP*DW-1:0] i_wr_data;
    logic [NP-1:0]  o_almost_full, o_full;
    logic [NP*16-1:0] o_drop_cnt;
    logic           i_ready;
    logic [DW-1:0]  o_sdata;
    logic           o_sop, o_eop, o_vld;
    logic [1:0]     o_port;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int base;
    int n;
    logic [DW-1:0] s_data;
    logic s_sop, s_eop;
    logic [1:0] s_port;
    logic hit;

    logic [DW-1:0] cap_data [$];
    logic [1:0]    cap_port [$];
    logic          cap_sop  [$];
    logic          cap_eop  [$];
    int            cap_cyc  [$];

    ingress_pkt_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(64), .MAX_PKT(32)
    ) dut (
        .clk(clk), .rst(rst),
        .i_wr_sop(i_wr_sop), .i_wr_eop(i_wr_eop), .i_wr_vld(i_wr_vld), .i_wr_data(i_wr_data),
        .o_almost_full(o_almost_full), .o_full(o_full), .o_drop_cnt(o_drop_cnt),
        .i_ready(i_ready), .o_sdata(o_sdata), .o_sop(o_sop), .o_eop(o_eop),
        .o_vld(o_vld), .o_port(o_port)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Words that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && o_vld && i_ready) begin
            cap_data.push_back(o_sdata);
            cap_port.push_back(o_port);
            cap_sop.push_back(o_sop);
            cap_eop.push_back(o_eop);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wr();
        i_wr_sop  = '0;
        i_wr_eop  = '0;
        i_wr_vld  = '0;
        i_wr_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_wr();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_pkt(input int p, input int len, input logic [63:0] b);
        for (int i = 0; i < len; i++) begin
            clear_wr();
            i_wr_vld[p] = 1'b1;
            i_wr_sop[p] = (i == 0);
            i_wr_eop[p] = (i == len - 1);
            i_wr_data[p*DW +: DW] = b + 64'(i);
            tick();
        end
        clear_wr();
    endtask

    initial begin
        i_ready = 1'b1;
        clear_wr();
        repeat (2) tick();
        check("rst_vld", o_vld, 0);
        rst = 1'b0;
        tick();
        check("rst_sdata", o_sdata, 0);
        check("rst_sop_eop", {o_sop, o_eop}, 0);
        check("rst_port", o_port, 0);
        check("rst_drop", o_drop_cnt, 0);
        check("rst_flags", {o_full, o_almost_full}, 0);

        // single-word packet on port 2
        i_wr_vld[2] = 1'b1; i_wr_sop[2] = 1'b1; i_wr_eop[2] = 1'b1;
        i_wr_data[2*DW +: DW] = 64'hA5;
        tick();
        clear_wr();
        check("single_e0_vld", o_vld, 0);
        tick();
        check("single_e1_vld", o_vld, 0);
        tick();
        check("single_e2_vld", o_vld, 1);
        check("single_data", o_sdata, 64'hA5);
        check("single_sop_eop", {o_sop, o_eop}, 2'b11);
        check("single_port", o_port, 2);
        tick();
        check("single_done_vld", o_vld, 0);

        // four ports, 3-word packets each, round-robin from port 0
        do_reset();
        base = cap_data.size();
        for (int w = 0; w < 3; w++) begin
            for (int p = 0; p < NP; p++) begin
                i_wr_vld[p] = 1'b1;
                i_wr_sop[p] = (w == 0);
                i_wr_eop[p] = (w == 2);
                i_wr_data[p*DW +: DW] = 64'(p * 256 + w);
            end
            tick();
        end
        clear_wr();
        repeat (30) tick();
        n = cap_data.size() - base;
        check("rr_count", n, 12);
        if (n == 12) begin
            for (int k = 0; k < 12; k++) begin
                check($sformatf("rr_port[%0d]", k), cap_port[base+k], k / 3);
                check($sformatf("rr_data[%0d]", k), cap_data[base+k], 64'((k / 3) * 256 + k % 3));
                check($sformatf("rr_sop_eop[%0d]", k), {cap_sop[base+k], cap_eop[base+k]},
                      {k % 3 == 0, k % 3 == 2});
                if (k > 0)
                    check($sformatf("rr_gap[%0d]", k), cap_cyc[base+k] - cap_cyc[base+k-1],
                          (k % 3 == 0) ? 2 : 1);
            end
        end

        // stalls while streaming port 1 (5 words) then port 3 (2 words)
        i_ready = 1'b0;
        base = cap_data.size();
        send_pkt(1, 5, 64'h500);
        send_pkt(3, 2, 64'h700);
        for (int k = 0; k < 30; k++) begin
            i_ready = (k % 2 == 1);
            if (!i_ready && o_vld) begin
                s_data = o_sdata; s_sop = o_sop; s_eop = o_eop; s_port = o_port;
                tick();
                check($sformatf("stall_vld[%0d]", k), o_vld, 1);
                check($sformatf("stall_hold[%0d]", k), {o_sdata, o_sop, o_eop, o_port},
                      {s_data, s_sop, s_eop, s_port});
            end else begin
                tick();
            end
        end
        i_ready = 1'b1;
        repeat (10) tick();
        n = cap_data.size() - base;
        check("stall_count", n, 7);
        if (n == 7) begin
            for (int k = 0; k < 7; k++) begin
                check($sformatf("stall_port[%0d]", k), cap_port[base+k], (k < 5) ? 1 : 3);
                check($sformatf("stall_data[%0d]", k), cap_data[base+k],
                      (k < 5) ? 64'h500 + 64'(k) : 64'h700 + 64'(k - 5));
                check($sformatf("stall_sop_eop[%0d]", k), {cap_sop[base+k], cap_eop[base+k]},
                      {k == 0 || k == 5, k == 4 || k == 6});
            end
        end

        // admission: 40-word packet fills port 0, next packet is dropped
        do_reset();
        i_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            clear_wr();
            i_wr_vld[0] = 1'b1;
            i_wr_sop[0] = (i == 0);
            i_wr_eop[0] = (i == 39);
            i_wr_data[0 +: DW] = 64'h4000 + 64'(i);
            tick();
            if (i == 31) check("af_at_32", o_almost_full[0], 0);
            if (i == 32) check("af_at_33", o_almost_full[0], 1);
        end
        clear_wr();
        send_pkt(0, 10, 64'h9000);
        check("adm_drop_cnt0", o_drop_cnt[15:0], 1);
        check("adm_af0", o_almost_full[0], 1);
        check("adm_full0", o_full[0], 0);
        check("adm_head_vld", o_vld, 1);
        check("adm_head_data", o_sdata, 64'h4000);
        base = cap_data.size();
        i_ready = 1'b1;
        repeat (60) tick();
        n = cap_data.size() - base;
        check("adm_out_count", n, 40);
        if (n == 40) begin
            check("adm_first", cap_data[base], 64'h4000);
            check("adm_last", cap_data[base+39], 64'h4027);
            check("adm_last_eop", cap_eop[base+39], 1);
        end
        check("adm_af0_drained", o_almost_full[0], 0);

        // stray body words on port 1
        base = cap_data.size();
        for (int w = 0; w < 2; w++) begin
            clear_wr();
            i_wr_vld[1] = 1'b1;
            i_wr_data[1*DW +: DW] = 64'hBAD0 + 64'(w);
            tick();
        end
        clear_wr();
        repeat (6) tick();
        check("stray_drop_cnt1", o_drop_cnt[31:16], 2);
        check("stray_drop_cnt0", o_drop_cnt[15:0], 1);
        check("stray_no_out", cap_data.size() - base, 0);
        check("stray_vld", o_vld, 0);

        // reset during word 3 of a 6-word transfer
        do_reset();
        i_ready = 1'b1;
        send_pkt(2, 6, 64'h600);
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (o_vld && o_sdata == 64'h602) hit = 1'b1;
            else tick();
        end
        check("mid_rst_reached", hit, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_vld", o_vld, 0);
        check("mid_rst_sdata", o_sdata, 0);
        check("mid_rst_sop_eop_port", {o_sop, o_eop, o_port}, 0);
        repeat (2) tick();
        rst = 1'b0;
        base = cap_data.size();
        repeat (20) tick();
        check("post_rst_no_out", cap_data.size() - base, 0);
        check("post_rst_vld", o_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ingress_pkt_arbiter.md
# ingress_pkt_arbiter

Parametrised ingress stage of the multi-port shared buffer. It takes NUM_PORTS framed write streams (sop/eop/vld/data), buffers each in a per-port store-and-forward FIFO with packet-level admission control, and serialises complete packets onto one output stream. Selection is packet-granular round-robin, so packets are never interleaved. The output carries a source-port tag and obeys a valid/ready handshake toward the shared-buffer write logic.

## Interface
- NUM_PORTS, 4: number of ingress ports, 2..16
- DATA_WIDTH, 64: data word width
- FIFO_DEPTH, 64: words per port FIFO, power of 2, ≥ 4
- MAX_PKT, 32: maximum packet length in words, ≤ FIFO_DEPTH
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- i_wr_sop  in  NUM_PORTS  per-port start of packet
- i_wr_eop  in  NUM_PORTS  per-port end of packet
- i_wr_vld  in  NUM_PORTS  per-port word valid
- i_wr_data  in  NUM_PORTS*DATA_WIDTH  flattened, port p at [p*DATA_WIDTH +: DATA_WIDTH]
- o_almost_full  out  NUM_PORTS  free entries < MAX_PKT
- o_full  out  NUM_PORTS  FIFO occupancy == FIFO_DEPTH
- o_drop_cnt  out  NUM_PORTS*16  per-port saturating count of dropped packets/stray words
- i_ready  in  1  downstream accepts word
- o_sdata  out  DATA_WIDTH  serialised data
- o_sop, o_eop, o_vld  out  1 each  framing of o_sdata
- o_port  out  PORT_W  source port, PORT_W = max(1, clog2(NUM_PORTS))

## Operation
- Per-port FIFO entry = {sop, eop, data}; width DATA_WIDTH+2.
- Write side, per port, state in_pkt/drop:
  - vld&sop, not in_pkt: admitted if free ≥ MAX_PKT (sampled that cycle). Word written, in_pkt=1. Otherwise drop=1, drop_cnt+1, word discarded.
  - vld, in_pkt: word written. eop clears in_pkt, increments pkt_cnt.
  - vld, drop: discarded; eop clears drop.
  - vld, no sop, idle: stray word, discarded, drop_cnt+1.
  - sop while in_pkt: treated as body word; the stored sop bit is cleared.
  - vld&sop&eop: single-word packet.
- pkt_cnt[p] counts complete packets resident. +1 on eop write, −1 on eop pop; both in the same cycle leave it unchanged.
- Arbiter FSM:
  - IDLE: request r[p] = pkt_cnt[p] != 0. Grant the first requester searching from last+1 modulo NUM_PORTS, register grant, go to XFER. No request: stay.
  - XFER: pop the granted FIFO when (!o_vld | i_ready); load the output register. Popping the eop word sets last=grant and returns to IDLE.
- Grant is frozen for the whole packet; one idle cycle between packets.
- drop_cnt saturates at 16'hFFFF.

## Timing
- Reset values: o_vld/o_sop/o_eop=0, o_sdata=0, o_port=0, o_drop_cnt=0, o_full=0, o_almost_full=0. FIFOs empty, FSM IDLE, last=NUM_PORTS-1 so port 0 wins first.
- Reset mid-packet: all buffered and in-flight words are lost; no partial packet is emitted after release.
- Latency: an eop written at edge E0 with the FSM idle gives XFER at E1 and the first output word valid after E2. Subsequent words stream 1/cycle while i_ready=1.
- Handshake: a word transfers on edge with o_vld&i_ready. With o_vld&!i_ready, o_sdata/o_sop/o_eop/o_port hold stable.
- o_full/o_almost_full are registered, reflecting occupancy after the current edge. Simultaneous write and pop leave occupancy unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is log2(FIFO_DEPTH)+1 bits.

## Structure
- Shared package `sbuf_pkg`: DATA_WIDTH default, PORT_W function (clog2), entry layout constants SOP_BIT/EOP_BIT.
- Sub-module `pkt_fifo`: show-ahead synchronous FIFO with occupancy, full, almost_full(threshold), async active-high reset. Instantiated NUM_PORTS times by generate.
- Top holds write-side admission FSMs, pkt counters, RR arbiter and output register.

## Test plan
- Reset, then port 2 sends a single-word packet 0xA5 (sop=eop=1) → o_vld after 2 edges, o_sdata=0xA5, o_sop=o_eop=1, o_port=2.
- All 4 ports hold one 3-word packet each, i_ready=1 → outputs ports 0,1,2,3 in order, 3 contiguous words each, one idle cycle between packets, no interleaving.
- i_ready toggles 1/0 during a 5-word packet → every word emitted once, outputs stable while stalled, packet order preserved.
- FIFO_DEPTH=64, MAX_PKT=32: fill port 0 with a 40-word packet, then send a 10-word packet → second packet dropped, drop_cnt[0]=1, o_almost_full[0]=1.
- Port 1 sends 2 body words with no sop → both discarded, drop_cnt[1]=2, nothing output.
- Assert rst during word 3 of a 6-word transfer → outputs 0 immediately; after release, no words from that packet appear.
